// File: rtl/to_serial_hs.sv
// ---------------------------------------------------------------------------
// to_serial_hs
// Multi-channel parallel-to-digit-serial converter with valid/ready handshakes
// on both sides. Each channel's BW_IN-bit word is extended to NO_CYC*BW_OUT
// bits (zero pad or sign extension) and issued as NO_CYC digits of BW_OUT
// bits, LSB- or MSB-digit first. All channels share one handshake and one
// digit counter.
//
// Ports
//   clk        in   clock, all logic on posedge
//   rst        in   synchronous active-high reset
//   in_vld     in   input word valid
//   in_rdy     out  block accepts a word this cycle
//   data_in    in   [NO_CH-1:0][BW_IN-1:0] parallel words
//   out_vld    out  output digit valid
//   out_rdy    in   downstream accepts the digit this cycle
//   data_out   out  [NO_CH-1:0][BW_OUT-1:0] current digit per channel
//   out_first  out  digit index 0 of a word (qualified by out_vld)
//   out_last   out  digit index NO_CYC-1 of a word (qualified by out_vld)
//
// Optional feature: define TO_SERIAL_HS_SKID_EN to add a one-word holding
// register so in_rdy comes straight from a flop (no out_rdy -> in_rdy path).
// ---------------------------------------------------------------------------
module to_serial_hs #(
  parameter int NO_CH     = 10,
  parameter int BW_IN     = 8,
  parameter int BW_OUT    = 2,
  parameter int MSB_FIRST = 0,
  parameter int SIGN_EXT  = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_vld,
  output logic                            in_rdy,
  input  logic [NO_CH-1:0][BW_IN-1:0]     data_in,
  output logic                            out_vld,
  input  logic                            out_rdy,
  output logic [NO_CH-1:0][BW_OUT-1:0]    data_out,
  output logic                            out_first,
  output logic                            out_last
);

  localparam int NO_CYC = (BW_IN + BW_OUT - 1) / BW_OUT;
  localparam int EXT_W  = NO_CYC * BW_OUT;
  localparam int CNT_W  = (NO_CYC > 1) ? $clog2(NO_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NO_CYC - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                          state_reg, state_next;
  logic [CNT_W-1:0]                cnt_reg, cnt_next;
  logic [NO_CH-1:0][EXT_W-1:0]     ext_reg, ext_next;
  logic [CNT_W-1:0]                dig_idx;
  logic [NO_CH-1:0][BW_IN-1:0]     load_word;
  logic                            in_acc, out_acc, at_last, end_word, word_avail;

  // Widen one word: fill everything with the pad bit, then overlay the word.
  function automatic logic [EXT_W-1:0] extend(input logic [BW_IN-1:0] w);
    logic             pad_bit;
    logic [EXT_W-1:0] e;
    pad_bit         = (SIGN_EXT != 0) ? w[BW_IN-1] : 1'b0;
    e               = {EXT_W{pad_bit}};
    e[BW_IN-1:0]    = w;
    return e;
  endfunction

  assign out_vld   = (state_reg == SHIFT);
  assign at_last   = (cnt_reg == CNT_LAST);
  assign out_first = out_vld && (cnt_reg == '0);
  assign out_last  = out_vld && at_last;
  assign in_acc    = in_vld && in_rdy;
  assign out_acc   = out_vld && out_rdy;
  assign end_word  = out_acc && at_last;

  // cnt always counts issue order; the digit position is mirrored for MSB-first.
  assign dig_idx = (MSB_FIRST != 0) ? (CNT_LAST - cnt_reg) : cnt_reg;

  genvar gi, gk;
  generate
    for (gi = 0; gi < NO_CH; gi++) begin : g_ch
      logic [BW_OUT-1:0] digits [NO_CYC];
      for (gk = 0; gk < NO_CYC; gk++) begin : g_dig
        assign digits[gk] = ext_reg[gi][gk*BW_OUT +: BW_OUT];
      end
      assign data_out[gi] = digits[dig_idx];
    end
  endgenerate

`ifdef TO_SERIAL_HS_SKID_EN
  logic [NO_CH-1:0][BW_IN-1:0] hold_reg, hold_next;
  logic                        full_reg, full_next;
  logic                        in_rdy_reg;

  assign in_rdy = in_rdy_reg;
  // A buffered word has priority at end of word; it is always older.
  assign word_avail = full_reg || in_acc;
  assign load_word  = full_reg ? hold_reg : data_in;

  always_comb begin
    hold_next = hold_reg;
    full_next = full_reg;
    if (end_word && full_reg) begin
      full_next = 1'b0;
    end
    // A word arriving exactly at end of word with an empty buffer goes
    // straight to the shift register, so only park it otherwise.
    if (in_acc && (state_reg == SHIFT) && !end_word) begin
      hold_next = data_in;
      full_next = 1'b1;
    end
  end
`else
  logic rdy_en_reg;

  // rdy_en_reg keeps in_rdy low for the first cycle out of reset.
  assign in_rdy     = rdy_en_reg && ((state_reg == IDLE) || (out_last && out_rdy));
  assign word_avail = in_acc;
  assign load_word  = data_in;
`endif

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    ext_next   = ext_reg;
    case (state_reg)
      IDLE: begin
        if (in_acc) begin
          state_next = SHIFT;
          cnt_next   = '0;
          for (int c = 0; c < NO_CH; c++) ext_next[c] = extend(load_word[c]);
        end
      end
      SHIFT: begin
        if (out_acc) begin
          if (at_last) begin
            cnt_next = '0;
            if (word_avail) begin
              for (int c = 0; c < NO_CH; c++) ext_next[c] = extend(load_word[c]);
            end else begin
              state_next = IDLE;
            end
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      ext_reg    <= '0;
`ifdef TO_SERIAL_HS_SKID_EN
      hold_reg   <= '0;
      full_reg   <= 1'b0;
      in_rdy_reg <= 1'b0;
`else
      rdy_en_reg <= 1'b0;
`endif
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      ext_reg    <= ext_next;
`ifdef TO_SERIAL_HS_SKID_EN
      hold_reg   <= hold_next;
      full_reg   <= full_next;
      in_rdy_reg <= !full_next;
`else
      rdy_en_reg <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_to_serial_hs.sv
// Testbench for to_serial_hs: four instances (LSB/MSB-first 8->2 bit, and
// sign-extended / zero-padded 7->3 bit) with a scoreboard per instance.
module tb_to_serial_hs;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // group 1: NO_CH=2, BW_IN=8, BW_OUT=2 (u_a LSB-first, u_b MSB-first)
  logic            in_vld1, out_rdy1;
  logic [1:0][7:0] din1;
  logic            a_in_rdy, a_out_vld, a_first, a_last;
  logic [1:0][1:0] a_dout;
  logic            b_in_rdy, b_out_vld, b_first, b_last;
  logic [1:0][1:0] b_dout;

  // group 2: NO_CH=1, BW_IN=7, BW_OUT=3 (u_c sign-extend, u_d zero pad)
  logic            in_vld2, out_rdy2;
  logic [6:0]      din2;
  logic            c_in_rdy, c_out_vld, c_first, c_last;
  logic [2:0]      c_dout;
  logic            d_in_rdy, d_out_vld, d_first, d_last;
  logic [2:0]      d_dout;

  to_serial_hs #(.NO_CH(2), .BW_IN(8), .BW_OUT(2), .MSB_FIRST(0), .SIGN_EXT(1)) u_a (
    .clk(clk), .rst(rst), .in_vld(in_vld1), .in_rdy(a_in_rdy), .data_in(din1),
    .out_vld(a_out_vld), .out_rdy(out_rdy1), .data_out(a_dout),
    .out_first(a_first), .out_last(a_last));

  to_serial_hs #(.NO_CH(2), .BW_IN(8), .BW_OUT(2), .MSB_FIRST(1), .SIGN_EXT(1)) u_b (
    .clk(clk), .rst(rst), .in_vld(in_vld1), .in_rdy(b_in_rdy), .data_in(din1),
    .out_vld(b_out_vld), .out_rdy(out_rdy1), .data_out(b_dout),
    .out_first(b_first), .out_last(b_last));

  to_serial_hs #(.NO_CH(1), .BW_IN(7), .BW_OUT(3), .MSB_FIRST(0), .SIGN_EXT(1)) u_c (
    .clk(clk), .rst(rst), .in_vld(in_vld2), .in_rdy(c_in_rdy), .data_in(din2),
    .out_vld(c_out_vld), .out_rdy(out_rdy2), .data_out(c_dout),
    .out_first(c_first), .out_last(c_last));

  to_serial_hs #(.NO_CH(1), .BW_IN(7), .BW_OUT(3), .MSB_FIRST(0), .SIGN_EXT(0)) u_d (
    .clk(clk), .rst(rst), .in_vld(in_vld2), .in_rdy(d_in_rdy), .data_in(din2),
    .out_vld(d_out_vld), .out_rdy(out_rdy2), .data_out(d_dout),
    .out_first(d_first), .out_last(d_last));

  typedef struct packed {logic [1:0] d1; logic [1:0] d0; logic first; logic last;} dig2_t;
  typedef struct packed {logic [2:0] d; logic first; logic last;} dig3_t;

  dig2_t exp_a[$], exp_b[$];
  dig3_t exp_c[$], exp_d[$];
  int    pop_cyc_a[$];
  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;

  // Hand-computed digit tables.
  // word 0: ch0=0xB4, ch1=0xFF   word 1: ch0=0x1B, ch1=0x00
  logic [7:0] w_ch0 [2]        = '{8'hB4, 8'h1B};
  logic [7:0] w_ch1 [2]        = '{8'hFF, 8'h00};
  logic [1:0] a_ch0_tab [2][4] = '{'{2'd0, 2'd1, 2'd3, 2'd2}, '{2'd3, 2'd2, 2'd1, 2'd0}};
  logic [1:0] b_ch0_tab [2][4] = '{'{2'd2, 2'd3, 2'd1, 2'd0}, '{2'd0, 2'd1, 2'd2, 2'd3}};
  logic [1:0] ch1_tab [2]      = '{2'd3, 2'd0};
  // group 2 words: 7'h53, 7'h2A
  logic [6:0] w2 [2]           = '{7'h53, 7'h2A};
  logic [2:0] c_tab [2][3]     = '{'{3'd3, 3'd2, 3'd7}, '{3'd2, 3'd5, 3'd0}};
  logic [2:0] d_tab [2][3]     = '{'{3'd3, 3'd2, 3'd1}, '{3'd2, 3'd5, 3'd0}};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin : mon_a
    dig2_t act, e;
    if (!rst && a_out_vld && out_rdy1) begin
      act = {a_dout[1], a_dout[0], a_first, a_last};
      checks++;
      if (exp_a.size() == 0) begin
        errors++;
        $display("FAIL a_unexpected: got %h expected none", act);
      end else begin
        e = exp_a.pop_front();
        if (act !== e) begin
          errors++;
          $display("FAIL a_digit: got %h expected %h", act, e);
        end else $display("a digit ch1=%0d ch0=%0d first=%0b last=%0b", act.d1, act.d0, act.first, act.last);
      end
      pop_cyc_a.push_back(cyc);
    end
  end

  always @(negedge clk) begin : mon_b
    dig2_t act, e;
    if (!rst && b_out_vld && out_rdy1) begin
      act = {b_dout[1], b_dout[0], b_first, b_last};
      checks++;
      if (exp_b.size() == 0) begin
        errors++;
        $display("FAIL b_unexpected: got %h expected none", act);
      end else begin
        e = exp_b.pop_front();
        if (act !== e) begin
          errors++;
          $display("FAIL b_digit: got %h expected %h", act, e);
        end else $display("b digit ch1=%0d ch0=%0d first=%0b last=%0b", act.d1, act.d0, act.first, act.last);
      end
    end
  end

  always @(negedge clk) begin : mon_c
    dig3_t act, e;
    if (!rst && c_out_vld && out_rdy2) begin
      act = {c_dout, c_first, c_last};
      checks++;
      if (exp_c.size() == 0) begin
        errors++;
        $display("FAIL c_unexpected: got %h expected none", act);
      end else begin
        e = exp_c.pop_front();
        if (act !== e) begin
          errors++;
          $display("FAIL c_digit: got %h expected %h", act, e);
        end else $display("c digit %0d first=%0b last=%0b", act.d, act.first, act.last);
      end
    end
  end

  always @(negedge clk) begin : mon_d
    dig3_t act, e;
    if (!rst && d_out_vld && out_rdy2) begin
      act = {d_dout, d_first, d_last};
      checks++;
      if (exp_d.size() == 0) begin
        errors++;
        $display("FAIL d_unexpected: got %h expected none", act);
      end else begin
        e = exp_d.pop_front();
        if (act !== e) begin
          errors++;
          $display("FAIL d_digit: got %h expected %h", act, e);
        end else $display("d digit %0d first=%0b last=%0b", act.d, act.first, act.last);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push1(input int w);
    dig2_t e;
    for (int k = 0; k < 4; k++) begin
      e.d1 = ch1_tab[w]; e.d0 = a_ch0_tab[w][k]; e.first = (k == 0); e.last = (k == 3);
      exp_a.push_back(e);
      e.d0 = b_ch0_tab[w][k];
      exp_b.push_back(e);
    end
  endtask

  task automatic push2(input int w);
    dig3_t e;
    for (int k = 0; k < 3; k++) begin
      e.d = c_tab[w][k]; e.first = (k == 0); e.last = (k == 2);
      exp_c.push_back(e);
      e.d = d_tab[w][k];
      exp_d.push_back(e);
    end
  endtask

  // Present a word and hold it until accepted; returns 1 ns after the accepting edge.
  task automatic send1(input int w);
    int n = 0;
    din1[0] = w_ch0[w]; din1[1] = w_ch1[w]; in_vld1 = 1'b1;
    @(negedge clk);
    while (!a_in_rdy && n < 50) begin @(negedge clk); n++; end
    if (!a_in_rdy) begin
      checks++; errors++;
      $display("FAIL send1_timeout: got in_rdy=0 expected 1 within 50 cycles");
    end else begin
      push1(w);
    end
    @(posedge clk); #1;
  endtask

  task automatic send2(input int w);
    int n = 0;
    din2 = w2[w]; in_vld2 = 1'b1;
    @(negedge clk);
    while (!c_in_rdy && n < 50) begin @(negedge clk); n++; end
    if (!c_in_rdy) begin
      checks++; errors++;
      $display("FAIL send2_timeout: got in_rdy=0 expected 1 within 50 cycles");
    end else begin
      push2(w);
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_a.size() + exp_b.size() + exp_c.size() + exp_d.size()) != 0 && n < 60) begin
      @(negedge clk); n++;
    end
    check("drain_left", 32'(exp_a.size() + exp_b.size() + exp_c.size() + exp_d.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_out_vld"}, 32'(a_out_vld), 32'd0);
    check({tag, "_first"},   32'(a_first),   32'd0);
    check({tag, "_last"},    32'(a_last),    32'd0);
    check({tag, "_dout"},    32'(a_dout),    32'd0);
    check({tag, "_in_rdy"},  32'(a_in_rdy),  32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; in_vld1 = 1'b0; out_rdy1 = 1'b1; din1 = '0;
    in_vld2 = 1'b0; out_rdy2 = 1'b1; din2 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_state("reset");
    @(negedge clk);
    check("in_rdy_after_reset", 32'(a_in_rdy), 32'd1);
    @(posedge clk); #1;

    // basic word, first-digit latency of one cycle
    check("idle_out_vld", 32'(a_out_vld), 32'd0);
    send1(0);
    in_vld1 = 1'b0;
    @(negedge clk);
    check("latency_out_vld", 32'(a_out_vld), 32'd1);
    check("latency_first", 32'(b_first), 32'd1);
    drain();

    // stall at digit 1 for 3 cycles
    send1(0);
    in_vld1 = 1'b0;
    @(posedge clk); #1 out_rdy1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_a_dout", 32'(a_dout[0]), 32'd1);
      check("stall_b_dout", 32'(b_dout[0]), 32'd3);
      check("stall_first", 32'(a_first), 32'd0);
      check("stall_out_vld", 32'(a_out_vld), 32'd1);
`ifdef TO_SERIAL_HS_SKID_EN
      check("stall_in_rdy", 32'(a_in_rdy), 32'd1);
`else
      check("stall_in_rdy", 32'(a_in_rdy), 32'd0);
`endif
    end
    @(posedge clk); #1 out_rdy1 = 1'b1;
    drain();

    // back-to-back words, no bubble
    pop_cyc_a.delete();
    send1(0);
    send1(1);
    in_vld1 = 1'b0;
    @(negedge clk);
    check("b2b_in_rdy_busy", 32'(a_in_rdy), 32'd0);
    drain();
    check("b2b_digit_count", 32'(pop_cyc_a.size()), 32'd8);
    if (pop_cyc_a.size() == 8)
      check("b2b_span", 32'(pop_cyc_a[7] - pop_cyc_a[0]), 32'd7);

    // non-divisible widths, sign extend vs zero pad, back-to-back
    send2(0);
    send2(1);
    in_vld2 = 1'b0;
    drain();

    // reset at digit 2 drops the word
    send1(0);
    in_vld1 = 1'b0;
    @(posedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    exp_a.delete(); exp_b.delete();
    @(negedge clk);
    check_reset_state("midrst");
    @(posedge clk); #1;
    send1(1);
    in_vld1 = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
